mem_lsu: RTL and testbench
==========================

# mem_lsu

Load/store unit that masters a single-port, word-wide RAM (synchronous write, combinational read, no byte enables) on behalf of the CPU pipeline. It accepts one byte/halfword/word request at a time over a valid/ready handshake. It performs read-modify-write for sub-word stores and returns extended load data over a valid/ready response channel. It sits between the execute stage and the data RAM.

## Interface
- ADDR_W, 32: CPU byte-address width.
- RAM_AW, 10: RAM word-index width (1024 words).

- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle, request accepted when valid&ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word; 3 treated as word.
- req_signed  in  1  sign-extend load data.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  32  extended load data; 0 for stores.
- rsp_err  out  1  misaligned access (only with trap macro).
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_adr  out  RAM_AW  word index = addr[RAM_AW+1:2].
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data, valid combinationally in the same cycle as ram_adr.

## Operation
- FSM states: IDLE, RD, WR, RSP. Reset state IDLE.
- IDLE: req_ready=1. On accept, latch we/size/signed/addr/wdata.
  - Load -> RD.
  - Word store -> WR.
  - Sub-word store -> RD.
- RD: ram_en=1, ram_we=0. Capture ram_dout into the data register at clock edge.
  - Load -> RSP.
  - Store -> WR.
- WR: ram_en=1, ram_we=1, ram_din = merged word.
  - Word: ram_din = wdata.
  - Half: lane addr[1] replaced with wdata[15:0].
  - Byte: lane addr[1:0] replaced with wdata[7:0].
  - Little-endian: lane 0 = bits 7:0.
  - Next state RSP.
- RSP: rsp_valid=1. rsp_rdata/rsp_err are held stable until rsp_ready=1, then -> IDLE.
- Load extraction: select lane as above, then zero- or sign-extend per req_signed. Word loads are passed through unchanged.
- Addresses above RAM range: upper bits are ignored and the index wraps modulo 2^RAM_AW.
- ram_en=ram_we=0 in IDLE and RSP. ram_adr holds the last latched address.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_en=0, ram_we=0, ram_adr=0, ram_din=0.
- Accept at edge T:
  - Load: RD in cycle T+1, rsp_valid from T+2.
  - Word store: WR in T+1, rsp_valid from T+2.
  - Sub-word store: RD T+1, WR T+2, rsp_valid from T+3.
- Only one outstanding request. req_ready=0 in every state except IDLE, so there is no request/response overlap.
- rsp_ready held low: unit stalls in RSP indefinitely, with outputs stable.
- Response consumed at edge E: req_ready=1 in cycle E+1. A new request cannot be accepted in the same cycle as the response handoff.
- Reset mid-operation: immediate return to IDLE and ram_en/ram_we drop asynchronously.
  - Reset asserted in RD aborts the access with no RAM write.
  - Reset asserted during WR before the edge leaves that write undefined.
  - A pending response is discarded.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]!=0, goes IDLE -> RSP directly.
  - rsp_valid appears at T+1 with rsp_err=1 and rsp_rdata=0.
  - No RAM access occurs (ram_en stays 0).
- Undefined:
  - rsp_err is tied 0.
  - Low address bits are masked (halfword addr[0]=0, word addr[1:0]=0) and the access proceeds normally.

## Test plan
- Word store 0xDEADBEEF to addr 0x10, then word load from 0x10 -> ram_adr=4, rsp_rdata=0xDEADBEEF; load rsp_valid two cycles after accept.
- With RAM word 4 = 0x11223344, byte store 0xAA to 0x12 -> RAM word becomes 0x11AA3344; rsp_valid three cycles after accept.
- Loads from that word:
  - Signed byte at 0x12 -> 0xFFFFFFAA.
  - Unsigned byte -> 0x000000AA.
  - Signed half at 0x12 -> 0x000011AA.
- Hold rsp_ready=0 for 5 cycles after a load -> rsp_valid and rsp_rdata stable, req_ready=0, ram_en=0 throughout.
- Word load at 0x13:
  - With macro: rsp_err=1 at T+1, ram_en never asserted.
  - Without macro: reads word index 4.
- Assert rst_n=0 during RD of a half store -> ram_en=0 immediately, RAM word unchanged, req_ready=1 after release.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit mastering a single-port word-wide RAM.
// Handles byte/half/word accesses one at a time. Sub-word stores are done as
// read-modify-write. Load data is lane-selected and zero/sign-extended.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word accesses respond immediately with rsp_err=1 and never touch the RAM.
// When it is undefined, the low address bits are masked and the access proceeds.
module mem_lsu #(
    parameter int ADDR_W = 32,
    parameter int RAM_AW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_adr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RSP
    } state_t;

    state_t state, state_nx;

    // Latched request fields. Only the address bits that select a byte in RAM
    // are kept; higher bits are ignored so the word index wraps.
    logic              we_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [RAM_AW+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       data_q;

    logic        accept;
    logic        req_misalign;
    logic [31:0] merged;
    logic [31:0] load_data;
    logic [7:0]  lane8;
    logic [15:0] lane16;

    // Upper address bits beyond the RAM range intentionally have no effect.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[ADDR_W-1:RAM_AW+2];

    assign accept = req_valid & req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
    logic err_q;

    // Half with addr[0] set, or word (size 2 or 3) with any low bit set.
    assign req_misalign = ((req_size == 2'd1) && req_addr[0]) ||
                          (req_size[1] && (req_addr[1:0] != 2'b00));

    // Remember whether the accepted request trapped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= req_misalign;
        end
    end

    assign rsp_err = (state == RSP) & err_q;
`else
    assign req_misalign = 1'b0;
    assign rsp_err      = 1'b0;
`endif

    // State register; async reset drops the RAM strobes immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples the values from before this edge.
            state <= state_nx;
        end
    end

    // Next-state logic and per-state handshake / RAM strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_nx  = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_misalign)
                        state_nx = RSP;
                    else if (req_we && req_size[1])
                        state_nx = WR;
                    else
                        state_nx = RD;
                end
            end
            RD: begin
                ram_en   = 1'b1;
                state_nx = we_q ? WR : RSP;
            end
            WR: begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                state_nx = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request capture on accept, and RAM read capture while in RD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            data_q   <= '0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                size_q   <= req_size;
                signed_q <= req_signed;
                addr_q   <= req_addr[RAM_AW+1:0];
                wdata_q  <= req_wdata;
            end
            if (state == RD)
                data_q <= ram_dout;
        end
    end

    // Store merge: replace the addressed lane of the read word (little-endian).
    always_comb begin
        merged = data_q;
        case (size_q)
            2'd0:    merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            2'd1:    merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // Load extraction: pick the lane, then zero- or sign-extend.
    always_comb begin
        lane8     = data_q[{addr_q[1:0], 3'b000} +: 8];
        lane16    = data_q[{addr_q[1], 4'b0000} +: 16];
        load_data = data_q;
        case (size_q)
            2'd0:    load_data = {{24{signed_q & lane8[7]}}, lane8};
            2'd1:    load_data = {{16{signed_q & lane16[15]}}, lane16};
            default: load_data = data_q;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign rsp_rdata = (state == RSP && !we_q && !err_q) ? load_data : 32'd0;
`else
    assign rsp_rdata = (state == RSP && !we_q) ? load_data : 32'd0;
`endif

    assign ram_adr = addr_q[RAM_AW+1:2];
    assign ram_din = (state == WR) ? merged : 32'd0;

endmodule

// File: tb/tb_mem_lsu.sv
// Testbench for mem_lsu: reset values, a directed vector table, stall/trap/reset
// sequences, and randomized traffic checked against a byte-array model.
module tb_mem_lsu;

    localparam int ADDR_W = 32;
    localparam int RAM_AW = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'd0;
    logic              req_signed = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              ram_en;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_adr;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_lsu #(.ADDR_W(ADDR_W), .RAM_AW(RAM_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_adr(ram_adr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    // The RAM the unit masters: synchronous write, combinational read.
    logic [31:0] ram [1024];
    assign ram_dout = ram[ram_adr];
    always @(posedge clk) begin
        if (ram_en && ram_we)
            ram[ram_adr] <= ram_din;
    end

    // Reference model: flat byte array, wraps at 4 KiB.
    logic [7:0] ref_mem [4096];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output int lat, output logic err);
        int nbytes;
        int base;
        longint v;
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        base   = int'(addr % 4096);
        rd     = 32'd0;
        err    = 1'b0;
        lat    = 2;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((base % nbytes) != 0) begin
            err = 1'b1;
            lat = 1;
            return;
        end
`endif
        base = base - (base % nbytes);
        if (we) begin
            for (int i = 0; i < nbytes; i++)
                ref_mem[base + i] = wdata[8*i +: 8];
            lat = (nbytes == 4) ? 2 : 3;
        end else begin
            v = 0;
            for (int i = 0; i < nbytes; i++)
                v = v + (longint'(ref_mem[base + i]) << (8 * i));
            if (sgn && nbytes < 4 && v >= (64'sd1 <<< (8 * nbytes - 1)))
                v = v - (64'sd1 <<< (8 * nbytes));
            rd  = v[31:0];
            lat = 2;
        end
    endtask

    // One complete transaction. Returns latency from accept edge to the first
    // cycle with rsp_valid, the response, whether ram_en was ever seen, and
    // ram_adr during the response. Holds rsp_ready low for 'stall' cycles.
    task automatic xact(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output logic en_seen, output logic [RAM_AW-1:0] adr);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready)
            check("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        lat     = 0;
        en_seen = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            req_valid = 1'b0;
            en_seen   = en_seen | ram_en;
        end while (!rsp_valid && lat < 20);
        rdata = rsp_rdata;
        err   = rsp_err;
        adr   = ram_adr;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_hold", {28'd0, rsp_valid, req_ready, ram_en, rsp_rdata == rdata}, 32'b1001);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_rsp_idle", {30'd0, rsp_valid, req_ready}, 32'b01);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t              vecs[$];
        int                lat, m_lat;
        logic [31:0]       rdata, m_rd;
        logic              err, m_err, en_seen;
        logic [RAM_AW-1:0] adr;
        logic              r_we, r_sgn;
        logic [1:0]        r_size;
        logic [31:0]       r_addr, r_wdata;

        for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd0;

        // Directed vectors, expected values worked out by hand.
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        2});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 2});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h10,   32'h11223344, 32'h0,        2});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h12,   32'h000000AA, 32'h0,        3});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'h11AA3344, 2});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h12,   32'h0,        32'hFFFFFFAA, 2});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h12,   32'h0,        32'h000000AA, 2});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h12,   32'h0,        32'h000011AA, 2});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h1E,   32'hFFFF8001, 32'h0,        3});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h1E,   32'h0,        32'hFFFF8001, 2});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h1E,   32'h0,        32'h00008001, 2});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h1F,   32'h0,        32'hFFFFFF80, 2});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h10,   32'h0,        32'h11AA3344, 2});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h1020, 32'hCAFEF00D, 32'h0,        2});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h20,   32'h0,        32'hCAFEF00D, 2});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'hFFFF_F010, 32'h0,   32'h11AA3344, 2});

        // Reset values, sampled while reset is held.
        #12;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
        check("rst_ram_en",    {31'd0, ram_en}, 32'd0);
        check("rst_ram_we",    {31'd0, ram_we}, 32'd0);
        check("rst_ram_adr",   {22'd0, ram_adr}, 32'd0);
        check("rst_ram_din",   ram_din, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven directed vectors.
        foreach (vecs[i]) begin
            model(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, m_rd, m_lat, m_err);
            xact(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, 0,
                 lat, rdata, err, en_seen, adr);
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_err", i), {31'd0, err}, 32'd0);
            if (i == 1)
                check("vec1_ram_adr", {22'd0, adr}, 32'd4);
        end

        // Load with the response stalled for five cycles.
        xact(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 5, lat, rdata, err, en_seen, adr);
        check("stall_rdata", rdata, 32'hFFFFFFAA);

        // Misaligned word load at 0x13.
        xact(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 0, lat, rdata, err, en_seen, adr);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_lat",   lat, 1);
        check("mis_err",   {31'd0, err}, 32'd1);
        check("mis_rdata", rdata, 32'd0);
        check("mis_no_ram", {31'd0, en_seen}, 32'd0);
`else
        check("mis_lat",   lat, 2);
        check("mis_err",   {31'd0, err}, 32'd0);
        check("mis_rdata", rdata, 32'h11AA3344);
        check("mis_adr",   {22'd0, adr}, 32'd4);
`endif

        // Reset asserted while a half store is in its read phase.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0000BEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_in_rd", {31'd0, ram_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_en_drop", {30'd0, ram_en, ram_we}, 32'd0);
        check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, lat, rdata, err, en_seen, adr);
        check("abort_ram_kept", rdata, 32'h11AA3344);

        // Randomized traffic against the byte-array model.
        for (int n = 0; n < 300; n++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_size  = 2'($urandom_range(0, 3));
            r_sgn   = 1'($urandom_range(0, 1));
            r_addr  = $urandom_range(0, 63) | (32'($urandom_range(0, 3)) << 12);
            r_wdata = $urandom;
            model(r_we, r_size, r_sgn, r_addr, r_wdata, m_rd, m_lat, m_err);
            xact(r_we, r_size, r_sgn, r_addr, r_wdata, 0, lat, rdata, err, en_seen, adr);
            check($sformatf("rnd%0d_rdata", n), rdata, m_rd);
            check($sformatf("rnd%0d_lat", n), lat, m_lat);
            check($sformatf("rnd%0d_err", n), {31'd0, err}, {31'd0, m_err});
            if (m_err)
                check($sformatf("rnd%0d_no_ram", n), {31'd0, en_seen}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
